// File: rtl/aes_hls_harness.sv
// Memory-and-control harness for the HLS AES core: host-loaded plaintext/key RAMs,
// a dual-port ciphertext capture RAM and an ap_start/ap_done sequencer with abort timer.
module aes_hls_harness #(
    parameter int DATA_W  = 1,
    parameter int ADDR_W  = 7,
    parameter int KEY_W   = 8,
    parameter int KEY_AW  = 4,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              pt_wr_en,
    input  logic [ADDR_W-1:0] pt_wr_addr,
    input  logic [DATA_W-1:0] pt_wr_data,
    input  logic              key_wr_en,
    input  logic [KEY_AW-1:0] key_wr_addr,
    input  logic [KEY_W-1:0]  key_wr_data,

    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  run_count,

    input  logic [ADDR_W-1:0] ct_rd_addr,
    output logic [DATA_W-1:0] ct_rd_data,

    output logic              ap_start,
    input  logic              ap_done,
    input  logic              ap_idle,
    input  logic              ap_ready,

    input  logic [ADDR_W-1:0] plain_text_address0,
    input  logic [ADDR_W-1:0] plain_text_address1,
    input  logic              plain_text_ce0,
    input  logic              plain_text_ce1,
    output logic [DATA_W-1:0] plain_text_q0,
    output logic [DATA_W-1:0] plain_text_q1,

    input  logic [KEY_AW-1:0] key_address0,
    input  logic [KEY_AW-1:0] key_address1,
    input  logic              key_ce0,
    input  logic              key_ce1,
    output logic [KEY_W-1:0]  key_q0,
    output logic [KEY_W-1:0]  key_q1,

    input  logic [ADDR_W-1:0] cipher_text_address0,
    input  logic [ADDR_W-1:0] cipher_text_address1,
    input  logic              cipher_text_ce0,
    input  logic              cipher_text_ce1,
    input  logic              cipher_text_we0,
    input  logic              cipher_text_we1,
    input  logic [DATA_W-1:0] cipher_text_d0,
    input  logic [DATA_W-1:0] cipher_text_d1
);

    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int KEY_DEPTH = 2 ** KEY_AW;
    localparam int TMR_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [TMR_W-1:0] timer;
    logic             leaving;
    logic [1:0]       leave_to;

    logic [DATA_W-1:0] pt_mem  [DEPTH];
    logic [KEY_W-1:0]  key_mem [KEY_DEPTH];
    logic [DATA_W-1:0] ct_mem  [DEPTH];

    logic unused_ap_idle;
    assign unused_ap_idle = ap_idle;

    assign busy     = (state != S_IDLE);
    assign ap_start = (state == S_START);

    // ------------------------------------------------------------------
    // Plaintext and key RAMs: host writes only while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (pt_wr_en && state == S_IDLE) begin
            pt_mem[pt_wr_addr] <= pt_wr_data;
        end
        if (key_wr_en && state == S_IDLE) begin
            key_mem[key_wr_addr] <= key_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            plain_text_q0 <= '0;
            plain_text_q1 <= '0;
            key_q0        <= '0;
            key_q1        <= '0;
        end else begin
            if (plain_text_ce0) plain_text_q0 <= pt_mem[plain_text_address0];
            if (plain_text_ce1) plain_text_q1 <= pt_mem[plain_text_address1];
            if (key_ce0)        key_q0        <= key_mem[key_address0];
            if (key_ce1)        key_q1        <= key_mem[key_address1];
        end
    end

    // ------------------------------------------------------------------
    // Ciphertext RAM: port 1 is assigned last so it wins an address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (cipher_text_ce0 && cipher_text_we0) begin
            ct_mem[cipher_text_address0] <= cipher_text_d0;
        end
        if (cipher_text_ce1 && cipher_text_we1) begin
            ct_mem[cipher_text_address1] <= cipher_text_d1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ct_rd_data <= '0;
        end else begin
            ct_rd_data <= ct_mem[ct_rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        leaving  = 1'b0;
        leave_to = S_IDLE;
        case (state)
            S_START: begin
                leaving  = ap_ready;
                leave_to = ap_done ? S_DONE : S_RUN;
            end
            S_RUN: begin
                leaving  = ap_done;
                leave_to = S_DONE;
            end
            default: begin
                leaving  = 1'b0;
                leave_to = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            timeout   <= 1'b0;
            done      <= 1'b0;
            run_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        timeout <= 1'b0;
                        timer   <= '0;
                        state   <= S_START;
                    end
                end
                S_START, S_RUN: begin
                    // A legitimate transition out takes priority over the abort on the last cycle.
                    if (leaving) begin
                        state <= leave_to;
                        timer <= timer + TMR_W'(1);
                        if (leave_to == S_DONE) done <= 1'b1;
                    end else if (timer == TMR_LAST) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_DONE: begin
                    run_count <= run_count + CNT_W'(1);
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_hls_harness.sv
// Directed bench for aes_hls_harness: RAM ports, sequencer handshake, timeout and reset.
module tb_aes_hls_harness;

    localparam int DATA_W  = 1;
    localparam int ADDR_W  = 7;
    localparam int KEY_W   = 8;
    localparam int KEY_AW  = 4;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              pt_wr_en;
    logic [ADDR_W-1:0] pt_wr_addr;
    logic [DATA_W-1:0] pt_wr_data;
    logic              key_wr_en;
    logic [KEY_AW-1:0] key_wr_addr;
    logic [KEY_W-1:0]  key_wr_data;
    logic              go;
    logic              busy, done, timeout;
    logic [CNT_W-1:0]  run_count;
    logic [ADDR_W-1:0] ct_rd_addr;
    logic [DATA_W-1:0] ct_rd_data;
    logic              ap_start, ap_done, ap_idle, ap_ready;
    logic [ADDR_W-1:0] pt_a0, pt_a1;
    logic              pt_ce0, pt_ce1;
    logic [DATA_W-1:0] pt_q0, pt_q1;
    logic [KEY_AW-1:0] key_a0, key_a1;
    logic              key_ce0, key_ce1;
    logic [KEY_W-1:0]  key_q0, key_q1;
    logic [ADDR_W-1:0] ct_a0, ct_a1;
    logic              ct_ce0, ct_ce1, ct_we0, ct_we1;
    logic [DATA_W-1:0] ct_d0, ct_d1;

    aes_hls_harness #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .KEY_W(KEY_W), .KEY_AW(KEY_AW),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .pt_wr_en(pt_wr_en), .pt_wr_addr(pt_wr_addr), .pt_wr_data(pt_wr_data),
        .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
        .go(go), .busy(busy), .done(done), .timeout(timeout), .run_count(run_count),
        .ct_rd_addr(ct_rd_addr), .ct_rd_data(ct_rd_data),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .plain_text_address0(pt_a0), .plain_text_address1(pt_a1),
        .plain_text_ce0(pt_ce0), .plain_text_ce1(pt_ce1),
        .plain_text_q0(pt_q0), .plain_text_q1(pt_q1),
        .key_address0(key_a0), .key_address1(key_a1),
        .key_ce0(key_ce0), .key_ce1(key_ce1),
        .key_q0(key_q0), .key_q1(key_q1),
        .cipher_text_address0(ct_a0), .cipher_text_address1(ct_a1),
        .cipher_text_ce0(ct_ce0), .cipher_text_ce1(ct_ce1),
        .cipher_text_we0(ct_we0), .cipher_text_we1(ct_we1),
        .cipher_text_d0(ct_d0), .cipher_text_d1(ct_d1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int starts, dones, n_busy, ready_i, apdone_i, done_i, seen;
    logic to_at_done, start_at_done, busy_at_done;

    initial begin
        reset = 1'b0;
        {pt_wr_en, key_wr_en, go, ap_done, ap_idle, ap_ready} = '0;
        {pt_wr_addr, pt_wr_data, key_wr_addr, key_wr_data, ct_rd_addr} = '0;
        {pt_a0, pt_a1, pt_ce0, pt_ce1, key_a0, key_a1, key_ce0, key_ce1} = '0;
        {ct_a0, ct_a1, ct_ce0, ct_ce1, ct_we0, ct_we1, ct_d0, ct_d1} = '0;
        repeat (3) step();
        reset = 1'b1;

        // 1. reset state
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_run_count", run_count, 0);
        check("rst_ap_start", ap_start, 0);
        check("rst_q", {pt_q0, pt_q1, key_q0, key_q1, ct_rd_data}, 0);
        step();
        check("q_before_ce", {pt_q0, pt_q1, key_q0, key_q1}, 0);

        // 2. host loads, core reads
        pt_wr_en = 1; pt_wr_addr = 5; pt_wr_data = 1;
        key_wr_en = 1; key_wr_addr = 3; key_wr_data = 8'h91;
        step();
        pt_wr_en = 0; key_wr_en = 0;
        pt_a0 = 5; pt_ce0 = 1; pt_a1 = 5; pt_ce1 = 1;
        key_a0 = 3; key_ce0 = 1; key_a1 = 3; key_ce1 = 1;
        step();
        check("pt_q0_read", pt_q0, 1);
        check("pt_q1_read", pt_q1, 1);
        check("key_q0_read", key_q0, 8'h91);
        check("key_q1_read", key_q1, 8'h91);
        pt_ce0 = 0; pt_ce1 = 0; key_ce0 = 0; key_ce1 = 0;
        pt_a0 = 6; pt_a1 = 6; key_a0 = 4; key_a1 = 4;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pt_q0_hold", pt_q0, 1);
            check("key_q1_hold", key_q1, 8'h91);
        end
        // same-cycle write and read of key[3] returns old data
        key_wr_en = 1; key_wr_addr = 3; key_wr_data = 8'h22;
        key_a0 = 3; key_ce0 = 1;
        step();
        key_wr_en = 0;
        check("key_rw_old", key_q0, 8'h91);
        step();
        key_ce0 = 0;
        check("key_rw_new", key_q0, 8'h22);

        // 3. normal run with delayed ap_ready
        go = 1;
        step();
        go = 0;
        starts = 0; dones = 0; ready_i = -1; apdone_i = -1; done_i = -1;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) check("go_latency", ap_start, 1);
            if (ap_start) starts++;
            if (done) begin dones++; done_i = i; end
            ap_ready = ap_start && (starts == 3);
            if (ap_ready) ready_i = i;
            ap_done = (ready_i >= 0) && (i == ready_i + 10);
            if (ap_done) apdone_i = i;
            step();
        end
        check("start_cycles", starts, 3);
        check("done_pulses", dones, 1);
        check("done_latency", done_i, apdone_i + 1);
        check("run_count_1", run_count, 1);
        check("busy_after_run", busy, 0);

        // ap_done while idle is ignored
        ap_done = 1;
        step();
        ap_done = 0;
        check("idle_ap_done", {done, busy}, 0);
        step();
        check("idle_ap_done_cnt", run_count, 1);

        // 4. ciphertext collisions and old-data reads
        ct_a0 = 7'h10; ct_a1 = 7'h10; ct_ce0 = 1; ct_ce1 = 1; ct_we0 = 1; ct_we1 = 1;
        ct_d0 = 0; ct_d1 = 1;
        step();
        ct_a0 = 7'h11; ct_a1 = 7'h20; ct_d0 = 1; ct_d1 = 1;
        step();
        ct_a0 = 7'h11; ct_a1 = 7'h11; ct_d0 = 1; ct_d1 = 0;
        step();
        // enabled but not write-enabled: no change to 0x20
        ct_a0 = 7'h20; ct_we0 = 0; ct_d0 = 0; ct_ce1 = 0; ct_we1 = 0;
        ct_rd_addr = 7'h10;
        step();
        ct_ce0 = 0;
        check("ct_collision_p1_one", ct_rd_data, 1);
        ct_rd_addr = 7'h11;
        step();
        check("ct_collision_p1_zero", ct_rd_data, 0);
        ct_rd_addr = 7'h20;
        step();
        check("ct_no_we", ct_rd_data, 1);
        ct_a0 = 7'h20; ct_ce0 = 1; ct_we0 = 1; ct_d0 = 0;
        step();
        ct_ce0 = 0; ct_we0 = 0;
        check("ct_rw_old", ct_rd_data, 1);
        step();
        check("ct_rw_new", ct_rd_data, 0);

        // 5. timeout
        go = 1;
        step();
        go = 0;
        n_busy = 0; seen = 0;
        to_at_done = 0; start_at_done = 1; busy_at_done = 1;
        for (int i = 0; i < 200; i++) begin
            if (busy) n_busy++;
            if (done) begin
                seen = 1;
                to_at_done = timeout; start_at_done = ap_start; busy_at_done = busy;
                break;
            end
            ap_ready = (i == 0);
            step();
        end
        ap_ready = 0;
        check("to_seen_done", seen, 1);
        check("to_busy_cycles", n_busy, TIMEOUT);
        check("to_flag", to_at_done, 1);
        check("to_ap_start", start_at_done, 0);
        check("to_busy", busy_at_done, 0);
        step();
        check("to_sticky", timeout, 1);
        check("to_done_pulse", done, 0);
        check("to_run_count", run_count, 1);
        go = 1;
        step();
        go = 0;
        check("to_cleared", timeout, 0);
        ap_ready = 1; ap_done = 1;
        step();
        ap_ready = 0; ap_done = 0;
        check("ready_done_same", done, 1);
        step();
        check("run_count_2", run_count, 2);

        // 6. activity during RUN, then reset
        pt_wr_en = 1; pt_wr_addr = 0; pt_wr_data = 0;
        step();
        pt_wr_en = 0;
        go = 1;
        step();
        go = 0; ap_ready = 1;
        step();
        ap_ready = 0;
        pt_wr_en = 1; pt_wr_addr = 0; pt_wr_data = 1; go = 1;
        step();
        pt_wr_en = 0; go = 0;
        check("run_busy", busy, 1);
        check("run_no_restart", ap_start, 0);
        step();
        check("run_no_restart2", {busy, ap_start}, 2'b10);
        reset = 0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_start", ap_start, 0);
        check("async_rst_cnt", run_count, 0);
        step();
        reset = 1;
        pt_a0 = 0; pt_ce0 = 1;
        step();
        pt_ce0 = 0;
        check("pt_write_dropped", pt_q0, 0);
        check("post_rst_idle", {busy, ap_start}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
